// File: rtl/stage3_fetch_unit.sv
// Fetch endpoint of the three-stage pipeline: PC register, instruction-bus
// request FSM, one-entry hold buffer and the IF/EX latch.
//
// state   | meaning
// IDLE    | no bus access, waiting for fetch enable
// REQ     | read issued at pc_f, waiting for imem_busy to drop
// HOLD    | completed word parked until the hazard unit grants pc_en
// DISCARD | redirected while busy; draining the stale access at stale_addr
module stage3_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic        insert_priv_pc,
    input  logic        rollback,
    input  logic [31:0] priv_pc,
    input  logic [31:0] brj_addr,
    input  logic [31:0] rollback_addr,
    input  logic        iren,
    input  logic        suppress_iren,
    input  logic        if_ex_stall,
    input  logic        if_ex_flush,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    output logic        i_mem_busy,
    output logic [31:0] pc_f,
    output logic        rv32c_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc4
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_stale_addr;
    logic [31:0] w_stale_nxt;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_nxt;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic        w_redirect;
    logic        w_gate;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    state_t      w_after_req;

    logic        r_fetch_valid;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_fetch_pc4;

    assign w_redirect   = pc_en & (insert_priv_pc | rollback | npc_sel);
    assign w_gate       = iren & ~suppress_iren;
    assign w_target_raw = insert_priv_pc ? priv_pc :
                          rollback       ? rollback_addr : brj_addr;
    assign w_target     = {w_target_raw[31:2], 2'b00};
    assign w_pc_inc     = r_pc + 32'd4;
    assign w_after_req  = w_gate ? S_REQ : S_IDLE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_stale_addr <= '0;
            r_hold_instr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_stale_addr <= w_stale_nxt;
            r_hold_instr <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_stale_nxt     = r_stale_addr;
        w_hold_nxt      = r_hold_instr;
        w_deliver       = 1'b0;
        w_deliver_instr = imem_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_redirect) w_pc_nxt = w_target;
                if (w_gate)     w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_busy) begin
                    // the bus must see a stable address, so retarget via DISCARD
                    if (w_redirect) begin
                        w_stale_nxt = r_pc;
                        w_pc_nxt    = w_target;
                        w_state_nxt = S_DISCARD;
                    end
                end else if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = w_after_req;
                end else if (pc_en) begin
                    w_deliver   = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = w_after_req;
                end else begin
                    w_hold_nxt  = imem_rdata;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (pc_en) begin
                    w_deliver       = 1'b1;
                    w_deliver_instr = r_hold_instr;
                    w_pc_nxt        = w_pc_inc;
                    w_state_nxt     = w_after_req;
                end
            end
            S_DISCARD: begin
                if (w_redirect) w_pc_nxt = w_target;
                if (!imem_busy) w_state_nxt = w_after_req;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
            r_fetch_pc    <= '0;
            r_fetch_pc4   <= '0;
        end else if (if_ex_flush) begin
            r_fetch_valid <= 1'b0;
        end else if (!if_ex_stall) begin
            if (w_deliver) begin
                r_fetch_valid <= 1'b1;
                r_fetch_instr <= w_deliver_instr;
                r_fetch_pc    <= r_pc;
                r_fetch_pc4   <= w_pc_inc;
            end else begin
                r_fetch_valid <= 1'b0;
            end
        end
    end

    // i_mem_busy depends only on state and imem_busy, never on pc_en
    assign imem_ren    = (r_state == S_REQ) | (r_state == S_DISCARD);
    assign imem_addr   = (r_state == S_DISCARD) ? r_stale_addr : r_pc;
    assign i_mem_busy  = ~((r_state == S_HOLD) | ((r_state == S_REQ) & ~imem_busy));
    assign pc_f        = r_pc;
    assign rv32c_ready = 1'b1;
    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_pc4   = r_fetch_pc4;

endmodule

// File: tb/tb_stage3_fetch_unit.sv
// Bench for stage3_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a transaction-level model.
module tb_stage3_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        pc_en = 1'b0, npc_sel = 1'b0, insert_priv_pc = 1'b0, rollback = 1'b0;
    logic [31:0] priv_pc = '0, brj_addr = '0, rollback_addr = '0;
    logic        iren = 1'b0, suppress_iren = 1'b0, if_ex_stall = 1'b0, if_ex_flush = 1'b0;
    logic        imem_busy = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_ren, i_mem_busy, rv32c_ready, fetch_valid;
    logic [31:0] imem_addr, pc_f, fetch_instr, fetch_pc, fetch_pc4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    stage3_fetch_unit dut (
        .CLK(CLK), .RST(RST), .pc_en(pc_en), .npc_sel(npc_sel),
        .insert_priv_pc(insert_priv_pc), .rollback(rollback),
        .priv_pc(priv_pc), .brj_addr(brj_addr), .rollback_addr(rollback_addr),
        .iren(iren), .suppress_iren(suppress_iren),
        .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush),
        .imem_busy(imem_busy), .imem_rdata(imem_rdata),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .i_mem_busy(i_mem_busy),
        .pc_f(pc_f), .rv32c_ready(rv32c_ready), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_pc4(fetch_pc4)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: a bus access is either live (to pc) or stale (to a remembered
    // address), and at most one completed word can be parked.
    bit          m_access   = 0;
    bit          m_stale    = 0;
    logic [31:0] m_stale_at = '0;
    bit          m_parked   = 0;
    logic [31:0] m_word     = '0;
    logic [31:0] m_pc       = 32'h8000_0000;
    bit          m_fv = 0;
    logic [31:0] m_fi = '0, m_fp = '0, m_fp4 = '0;

    always @(posedge CLK or posedge RST) begin
        logic [31:0] tgt, old_pc, word;
        bit redir, gate, got;
        if (RST) begin
            m_access = 0; m_stale = 0; m_stale_at = '0; m_parked = 0; m_word = '0;
            m_pc = 32'h8000_0000;
            m_fv = 0; m_fi = '0; m_fp = '0; m_fp4 = '0;
        end else begin
            tgt    = insert_priv_pc ? priv_pc : (rollback ? rollback_addr : brj_addr);
            tgt    = tgt & 32'hFFFF_FFFC;
            redir  = pc_en && (insert_priv_pc || rollback || npc_sel);
            gate   = iren && !suppress_iren;
            old_pc = m_pc;
            got    = 0;
            word   = '0;
            if (m_parked) begin
                if (redir) begin
                    m_parked = 0; m_pc = tgt; m_access = 1;
                end else if (pc_en) begin
                    got = 1; word = m_word; m_parked = 0;
                    m_pc = m_pc + 32'd4; m_access = gate;
                end
            end else if (m_access && m_stale) begin
                if (redir) m_pc = tgt;
                if (!imem_busy) begin
                    m_stale = 0; m_access = gate;
                end
            end else if (m_access) begin
                if (imem_busy) begin
                    if (redir) begin
                        m_stale = 1; m_stale_at = m_pc; m_pc = tgt;
                    end
                end else if (redir) begin
                    m_pc = tgt; m_access = gate;
                end else if (pc_en) begin
                    got = 1; word = imem_rdata;
                    m_pc = m_pc + 32'd4; m_access = gate;
                end else begin
                    m_parked = 1; m_word = imem_rdata; m_access = 0;
                end
            end else begin
                if (redir) m_pc = tgt;
                if (gate) m_access = 1;
            end
            if (if_ex_flush) m_fv = 0;
            else if (!if_ex_stall) begin
                m_fv = got;
                if (got) begin
                    m_fi = word; m_fp = old_pc; m_fp4 = old_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("imem_ren", imem_ren, m_access);
            chk("imem_addr", imem_addr, m_stale ? m_stale_at : m_pc);
            chk("i_mem_busy", i_mem_busy, !(m_parked || (m_access && !m_stale && !imem_busy)));
            chk("pc_f", pc_f, m_pc);
            chk("rv32c_ready", rv32c_ready, 1'b1);
            chk("fetch_valid", fetch_valid, m_fv);
            chk("fetch_instr", fetch_instr, m_fi);
            chk("fetch_pc", fetch_pc, m_fp);
            chk("fetch_pc4", fetch_pc4, m_fp4);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet_inputs();
        pc_en = 0; npc_sel = 0; insert_priv_pc = 0; rollback = 0;
        iren = 0; suppress_iren = 0; if_ex_stall = 0; if_ex_flush = 0;
        imem_busy = 0; imem_rdata = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        RST = 1;
        step();
        step();
        RST = 0;
    endtask

    initial begin
        do_reset();
        cmp_en = 1;
        chk("rst_ren", imem_ren, 1'b0);
        chk("rst_addr", imem_addr, 32'h8000_0000);
        chk("rst_busy", i_mem_busy, 1'b1);
        chk("rst_pcf", pc_f, 32'h8000_0000);
        chk("rst_fv", fetch_valid, 1'b0);
        chk("rst_fpc", fetch_pc, 32'h0);

        // zero-wait streaming
        iren = 1; pc_en = 1; imem_busy = 0;
        step();
        chk("zw_ren", imem_ren, 1'b1);
        chk("zw_addr0", imem_addr, 32'h8000_0000);
        imem_rdata = 32'hA000_0000;
        step();
        chk("zw_fv", fetch_valid, 1'b1);
        chk("zw_fpc", fetch_pc, 32'h8000_0000);
        chk("zw_fpc4", fetch_pc4, 32'h8000_0004);
        chk("zw_instr", fetch_instr, 32'hA000_0000);
        chk("zw_addr1", imem_addr, 32'h8000_0004);
        imem_rdata = 32'hA000_0001;
        step();
        chk("zw_fpc_b", fetch_pc, 32'h8000_0004);
        chk("zw_addr2", imem_addr, 32'h8000_0008);

        // redirect during a busy access
        do_reset();
        iren = 1; pc_en = 1; imem_busy = 1;
        step();
        npc_sel = 1; brj_addr = 32'h8000_0103;
        step();
        npc_sel = 0;
        chk("dis_addr1", imem_addr, 32'h8000_0000);
        chk("dis_pcf", pc_f, 32'h8000_0100);
        step();
        chk("dis_addr2", imem_addr, 32'h8000_0000);
        step();
        chk("dis_addr3", imem_addr, 32'h8000_0000);
        imem_busy = 0; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("dis_fv", fetch_valid, 1'b0);
        chk("dis_reissue", imem_addr, 32'h8000_0100);
        imem_rdata = 32'hB000_0000;
        step();
        chk("dis_instr", fetch_instr, 32'hB000_0000);
        chk("dis_fpc", fetch_pc, 32'h8000_0100);

        // completion without pc_en parks the word
        pc_en = 0; imem_rdata = 32'hC000_0000;
        step();
        chk("hold_ren", imem_ren, 1'b0);
        chk("hold_busy", i_mem_busy, 1'b0);
        imem_rdata = 32'h1234_5678;
        step();
        chk("hold_ren2", imem_ren, 1'b0);
        pc_en = 1;
        step();
        chk("hold_instr", fetch_instr, 32'hC000_0000);
        chk("hold_fpc", fetch_pc, 32'h8000_0104);
        chk("hold_next", imem_addr, 32'h8000_0108);

        // redirect priority
        insert_priv_pc = 1; rollback = 1; npc_sel = 1;
        priv_pc = 32'h8000_0200; rollback_addr = 32'h8000_0300; brj_addr = 32'h8000_0400;
        step();
        insert_priv_pc = 0; rollback = 0; npc_sel = 0;
        chk("prio_pcf", pc_f, 32'h8000_0200);

        // flush wins over stall; stall alone holds the latch
        imem_rdata = 32'hD000_0000;
        step();
        chk("fl_pre", fetch_valid, 1'b1);
        if_ex_flush = 1; if_ex_stall = 1; imem_rdata = 32'hD000_0001;
        step();
        chk("fl_fv", fetch_valid, 1'b0);
        if_ex_flush = 0; if_ex_stall = 0; imem_rdata = 32'hD000_0002;
        step();
        chk("st_pre", fetch_pc, 32'h8000_0208);
        if_ex_stall = 1; imem_rdata = 32'hD000_0003;
        step();
        chk("st_instr", fetch_instr, 32'hD000_0002);
        chk("st_fpc", fetch_pc, 32'h8000_0208);
        if_ex_stall = 0;

        // wrap at the top of the address space
        npc_sel = 1; brj_addr = 32'hFFFF_FFFE;
        step();
        npc_sel = 0;
        chk("wrap_tgt", pc_f, 32'hFFFF_FFFC);
        imem_rdata = 32'hE000_0000;
        step();
        chk("wrap_fpc", fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_fpc4", fetch_pc4, 32'h0000_0000);
        chk("wrap_pcf", pc_f, 32'h0000_0000);

        // reset while draining a stale access
        imem_busy = 1; npc_sel = 1; brj_addr = 32'h8000_0400;
        step();
        npc_sel = 0;
        chk("rd_stale", imem_addr, 32'h0000_0000);
        RST = 1;
        step();
        chk("rd_ren", imem_ren, 1'b0);
        chk("rd_addr", imem_addr, 32'h8000_0000);
        chk("rd_fv", fetch_valid, 1'b0);
        chk("rd_finstr", fetch_instr, 32'h0);
        RST = 0;
        step();
        chk("rd_req", imem_addr, 32'h8000_0000);
        imem_busy = 0; imem_rdata = 32'hF000_0000;
        step();
        chk("rd_instr", fetch_instr, 32'hF000_0000);
        chk("rd_fpc", fetch_pc, 32'h8000_0000);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            RST            = ($urandom_range(0, 499) == 0);
            pc_en          = ($urandom_range(0, 3) != 0);
            npc_sel        = ($urandom_range(0, 9) == 0);
            insert_priv_pc = ($urandom_range(0, 24) == 0);
            rollback       = ($urandom_range(0, 19) == 0);
            priv_pc        = $urandom;
            brj_addr       = $urandom;
            rollback_addr  = $urandom;
            iren           = ($urandom_range(0, 9) != 0);
            suppress_iren  = ($urandom_range(0, 9) == 0);
            if_ex_stall    = ($urandom_range(0, 9) == 0);
            if_ex_flush    = ($urandom_range(0, 19) == 0);
            imem_busy      = ($urandom_range(0, 2) == 0);
            imem_rdata     = $urandom;
            step();
        end
        RST = 0;
        step();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
